// File: rtl/serial_sub_pkg.sv
// Shared types and defaults for the bit-serial subtraction controller.
package serial_sub_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fs.sv
// Single-bit full subtractor: d = a - b - c, bo = borrow out.
module fs (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic d,
    output logic bo
);

    assign d  = a ^ b ^ c;
    assign bo = (~a & b) | (~(a ^ b) & c);

endmodule

// File: rtl/serial_sub_ctrl.sv
// Bit-serial A - B controller: LSB-first through one fs cell, start/busy/done handshake.
module serial_sub_ctrl
    import serial_sub_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    state_t           state_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic             brw_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cell_d;
    logic             cell_bo;
    logic [WIDTH-1:0] a_sh_next;

    fs u_fs (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .c  (brw_q),
        .d  (cell_d),
        .bo (cell_bo)
    );

    // Result bits enter the top of the minuend register as its bits are consumed,
    // so after WIDTH shifts it holds the complete difference.
    assign a_sh_next = {cell_d, a_sh_q[WIDTH-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            brw_q      <= 1'b0;
            cnt_q      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        a_sh_q  <= a_in;
                        b_sh_q  <= b_in;
                        brw_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sh_q <= a_sh_next;
                    b_sh_q <= b_sh_q >> 1;
                    brw_q  <= cell_bo;
                    cnt_q  <= cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        diff       <= a_sh_next;
                        borrow_out <= cell_bo;
                        state_q    <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: directed 8-bit vectors plus a 4-bit exhaustive sweep.
module tb_serial_sub_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0, diff8;
    logic       busy8, done8, brw8;

    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0, diff4;
    logic       busy4, done4, brw4;

    serial_sub_ctrl #(.WIDTH(8)) u_dut8 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start8),
        .a_in       (a8),
        .b_in       (b8),
        .busy       (busy8),
        .done       (done8),
        .diff       (diff8),
        .borrow_out (brw8)
    );

    serial_sub_ctrl #(.WIDTH(4)) u_dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start4),
        .a_in       (a4),
        .b_in       (b4),
        .busy       (busy4),
        .done       (done4),
        .diff       (diff4),
        .borrow_out (brw4)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    // Expected entries are {borrow, diff} zero-extended to 33 bits.
    logic [32:0] q8[$];
    logic [32:0] q4[$];
    int dones8 = 0;
    int dones4 = 0;

    // ---------------- monitors ----------------
    int          run8 = 0;
    logic [8:0]  last8 = '0;
    logic        prev_done8 = 1'b0;
    logic [32:0] e8;

    always @(negedge clk) begin
        if (!rst_n) begin
            run8 = 0;
            last8 = '0;
            prev_done8 = 1'b0;
        end else begin
            check("busy_and_done8", {31'b0, busy8 & done8}, 32'd0);
            if (busy8) run8++;
            if (done8) begin
                dones8++;
                check("busy_cycles8", run8, 8);
                check("done_pulse_len8", {31'b0, prev_done8}, 32'd0);
                run8 = 0;
                checks++;
                if (q8.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done8: diff 0x%0h with empty scoreboard", diff8);
                end else begin
                    e8 = q8.pop_front();
                    check("diff8", {24'b0, diff8}, {24'b0, e8[7:0]});
                    check("borrow8", {31'b0, brw8}, {31'b0, e8[32]});
                end
                last8 = {brw8, diff8};
            end else begin
                check("result_stable8", {23'b0, brw8, diff8}, {23'b0, last8});
            end
            prev_done8 = done8;
        end
    end

    int          run4 = 0;
    logic [4:0]  last4 = '0;
    logic        prev_done4 = 1'b0;
    logic [32:0] e4;

    always @(negedge clk) begin
        if (!rst_n) begin
            run4 = 0;
            last4 = '0;
            prev_done4 = 1'b0;
        end else begin
            if (busy4 && done4) check("busy_and_done4", 32'd1, 32'd0);
            if (busy4) run4++;
            if (done4) begin
                dones4++;
                check("busy_cycles4", run4, 4);
                if (prev_done4) check("done_pulse_len4", 32'd1, 32'd0);
                run4 = 0;
                checks++;
                if (q4.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_done4: diff 0x%0h with empty scoreboard", diff4);
                end else begin
                    e4 = q4.pop_front();
                    check("diff4", {28'b0, diff4}, {28'b0, e4[3:0]});
                    check("borrow4", {31'b0, brw4}, {31'b0, e4[32]});
                end
                last4 = {brw4, diff4};
            end else if ({brw4, diff4} !== last4) begin
                check("result_stable4", {27'b0, brw4, diff4}, {27'b0, last4});
            end
            prev_done4 = done4;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_idle8();
        int n = 0;
        @(negedge clk);
        while ((busy8 || done8) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout8", {31'b0, busy8 | done8}, 32'd0);
    endtask

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp_d, input logic exp_b);
        wait_idle8();
        a8 = a;
        b8 = b;
        start8 = 1'b1;
        q8.push_back({exp_b, 24'b0, exp_d});
        @(posedge clk);
        #1 start8 = 1'b0;
        a8 = ~a;
        b8 = ~b;
    endtask

    task automatic op4(input logic [3:0] a, input logic [3:0] b);
        int n = 0;
        @(negedge clk);
        while ((busy4 || done4) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("idle_timeout4", {31'b0, busy4 | done4}, 32'd0);
        a4 = a;
        b4 = b;
        start4 = 1'b1;
        q4.push_back({(a < b), 28'b0, 4'(a - b)});
        @(posedge clk);
        #1 start4 = 1'b0;
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while ((q8.size() != 0 || q4.size() != 0 || busy8 || done8 || busy4 || done4)
               && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL %s: scoreboard not drained, %0d/%0d entries left", name,
                     q8.size(), q4.size());
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int target;
        #1;
        check("reset_busy", {31'b0, busy8}, 32'd0);
        check("reset_done", {31'b0, done8}, 32'd0);
        check("reset_diff", {24'b0, diff8}, 32'd0);
        check("reset_borrow", {31'b0, brw8}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 8'h02, 1'b0);
        op8(8'h03, 8'h05, 8'hFE, 1'b1);
        op8(8'h00, 8'hFF, 8'h01, 1'b1);
        op8(8'hA5, 8'hA5, 8'h00, 1'b0);
        drain("basic_vectors", 200);

        // Start during RUN must be ignored.
        op8(8'h05, 8'h03, 8'h02, 1'b0);
        repeat (2) @(posedge clk);
        #1 start8 = 1'b1;
        a8 = 8'hFF;
        b8 = 8'h00;
        @(posedge clk);
        #1 start8 = 1'b0;
        drain("start_in_run", 100);

        // Start held high: three back-to-back operations.
        wait_idle8();
        target = dones8 + 3;
        repeat (3) q8.push_back({1'b1, 24'b0, 8'hF0});
        a8 = 8'h10;
        b8 = 8'h20;
        start8 = 1'b1;
        for (int n = 0; n < 60 && dones8 < target; n++) begin
            @(negedge clk);
            #1;
        end
        start8 = 1'b0;
        check("back_to_back_count", dones8, target);
        drain("back_to_back", 100);

        // Asynchronous reset in the middle of RUN.
        op8(8'h05, 8'h03, 8'h02, 1'b0);
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy8}, 32'd0);
        check("abort_done", {31'b0, done8}, 32'd0);
        check("abort_diff", {24'b0, diff8}, 32'd0);
        check("abort_borrow", {31'b0, brw8}, 32'd0);
        q8.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check("no_done_after_abort", {31'b0, done8}, 32'd0);
        op8(8'h80, 8'h01, 8'h7F, 1'b0);
        drain("after_abort", 100);

        // Exhaustive 4-bit sweep against the reference model.
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                op4(4'(a), 4'(b));
            end
        end
        drain("sweep4", 100);
        check("sweep4_done_count", dones4, 256);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
